// File: rtl/axil_ram_sp_pkg.sv
// axil_ram_sp_pkg: AXI-Lite response codes and read/write arbiter grant encoding.
package axil_ram_sp_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    typedef enum logic {GNT_WRITE = 1'b0, GNT_READ = 1'b1} gnt_e;
endpackage

// File: rtl/axil_ram_sp_arb_rr2.sv
// arb_rr2: two-requester round-robin arbiter; ties go opposite the last grant.
module arb_rr2
    import axil_ram_sp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_wr,
    input  logic i_req_rd,
    output logic o_gnt_wr,
    output logic o_gnt_rd
);
    gnt_e r_last;
    always_comb begin
        o_gnt_wr = i_req_wr && (!i_req_rd || r_last == GNT_READ);
        o_gnt_rd = i_req_rd && !o_gnt_wr;
    end
    always_ff @(posedge clk) begin
        if (rst) r_last <= GNT_READ;
        else if (o_gnt_wr) r_last <= GNT_WRITE;
        else if (o_gnt_rd) r_last <= GNT_READ;
    end
endmodule

// File: rtl/axil_ram_sp.sv
// axil_ram_sp: AXI4-Lite RAM on one memory port; reads and writes share it
// through a round-robin arbiter, out-of-range words answer DECERR.
module axil_ram_sp
    import axil_ram_sp_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int DEPTH           = 4096,
    parameter int PIPELINE_OUTPUT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);
    localparam int AW_LSB = $clog2(STRB_WIDTH);
    localparam int IDX_W  = ADDR_WIDTH - AW_LSB;
    localparam int MEM_AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
    logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
    logic                  w_wr_ok, w_rd_ok, w_wr_req, w_rd_req, w_gnt_wr, w_gnt_rd, w_rd_accept;
    logic                  r_awready, r_arready, r_bvalid, r_rvalid_int;
    logic [1:0]            r_bresp, r_rresp_int;
    logic [DATA_WIDTH-1:0] r_rdata_int;
    logic                  w_unused;

    assign w_unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};
    assign w_wr_idx = s_axil_awaddr[ADDR_WIDTH-1:AW_LSB];
    assign w_rd_idx = s_axil_araddr[ADDR_WIDTH-1:AW_LSB];
    assign w_wr_ok  = 32'(w_wr_idx) < DEPTH;
    assign w_rd_ok  = 32'(w_rd_idx) < DEPTH;
    // A channel whose ready is up is mid-access, so it cannot be granted again
    assign w_wr_req = s_axil_awvalid && s_axil_wvalid && (!r_bvalid || s_axil_bready) && !r_awready;
    assign w_rd_req = s_axil_arvalid && !r_arready && (!r_rvalid_int || w_rd_accept);

    arb_rr2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req_wr(w_wr_req),
        .i_req_rd(w_rd_req),
        .o_gnt_wr(w_gnt_wr),
        .o_gnt_rd(w_gnt_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_awready <= 1'b0;
            r_arready <= 1'b0;
        end else begin
            r_awready <= w_gnt_wr;
            r_arready <= w_gnt_rd;
        end
    end

    // Single port: awready and arready are never high together
    always_ff @(posedge clk) begin
        if (!rst && r_awready && w_wr_ok)
            for (int i = 0; i < STRB_WIDTH; i++)
                if (s_axil_wstrb[i]) r_mem[w_wr_idx[MEM_AW-1:0]][8*i +: 8] <= s_axil_wdata[8*i +: 8];
        if (rst) r_rdata_int <= '0;
        else if (r_arready) r_rdata_int <= w_rd_ok ? r_mem[w_rd_idx[MEM_AW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bvalid     <= 1'b0;
            r_bresp      <= RESP_OKAY;
            r_rvalid_int <= 1'b0;
            r_rresp_int  <= RESP_OKAY;
        end else begin
            if (r_awready) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_DECERR;
            end else if (s_axil_bready) r_bvalid <= 1'b0;
            if (r_arready) begin
                r_rvalid_int <= 1'b1;
                r_rresp_int  <= w_rd_ok ? RESP_OKAY : RESP_DECERR;
            end else if (w_rd_accept) r_rvalid_int <= 1'b0;
        end
    end

    assign s_axil_awready = r_awready;
    assign s_axil_wready  = r_awready;
    assign s_axil_arready = r_arready;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;

    if (PIPELINE_OUTPUT != 0) begin : g_pipe
        logic                  r_pvalid;
        logic [1:0]            r_presp;
        logic [DATA_WIDTH-1:0] r_pdata;
        assign w_rd_accept = s_axil_rready || !r_pvalid;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_pvalid <= 1'b0;
                r_presp  <= RESP_OKAY;
                r_pdata  <= '0;
            end else if (w_rd_accept) begin
                r_pvalid <= r_rvalid_int;
                r_presp  <= r_rresp_int;
                r_pdata  <= r_rdata_int;
            end
        end
        assign s_axil_rvalid = r_pvalid;
        assign s_axil_rresp  = r_presp;
        assign s_axil_rdata  = r_pdata;
    end else begin : g_direct
        assign w_rd_accept   = s_axil_rready;
        assign s_axil_rvalid = r_rvalid_int;
        assign s_axil_rresp  = r_rresp_int;
        assign s_axil_rdata  = r_rdata_int;
    end
endmodule
